// File: rtl/mem_entry_pkg.sv
// Shared types and helpers for the switch/key memory entry controller.
//   state_t   : controller state encoding
//   MODE_*    : operator-visible mode codes driven on the mode output
//   n_chunks  : number of CHUNK-sized entries needed to cover a field width
package mem_entry_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_ADDR,
    S_DATA,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;
  localparam logic [1:0] MODE_ERR   = 2'b11;

  function automatic int n_chunks(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/mem_entry_ctrl_timer.sv
// Request timeout counter for the WAIT phase.
//   clk     : system clock
//   clear   : synchronous clear (reset or soft reset)
//   run     : high while the controller waits for memory; low clears the count
//   expired : high during the TIMEOUT_CYC-th consecutive run cycle; never high
//             when TIMEOUT_CYC is 0
module mem_wait_timer #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int LAST  = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  logic [CNT_W-1:0] cnt;

  // Counts completed run cycles; saturates so a late expiry cannot wrap.
  always_ff @(posedge clk) begin
    if (clear || !run) begin
      cnt <= '0;
    end else if (cnt != CNT_W'(LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (TIMEOUT_CYC != 0) && run && (cnt == CNT_W'(LAST));

endmodule

// File: rtl/mem_entry_ctrl.sv
// Switch/key driven memory access controller. The operator selects read or
// write, keys in the address (and write data) in switch-sized chunks, and the
// block issues a single memory request and shows the read result.
//   clk, reset      : clock, synchronous active-high reset
//   key_chord       : soft reset, same effect as reset
//   key_mode_pulse  : mode toggle / abort / acknowledge
//   key_ent_pulse   : enter chunk / repeat access with address +1
//   sw              : switch value
//   mem_done        : memory completion pulse, read_data valid with it
//   mem_req/mem_we  : request level and direction
//   mem_addr        : request address
//   write_data      : request write data
//   display_data    : last read result
//   mode            : 00 idle/done, 01 read, 10 write, 11 error
//   entry_idx       : chunk index within the address or data phase
//   err             : timeout flag, held until acknowledged
//
// state  | meaning
// IDLE   | nothing selected
// SEL    | choosing read/write
// ADDR   | entering address chunks
// DATA   | entering write data chunks
// WAIT   | request outstanding
// DONE   | request complete, result shown
// ERR    | request timed out
module mem_entry_ctrl
  import mem_entry_pkg::*;
#(
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 16,
  parameter int SW_W        = 9,
  parameter int CHUNK_W     = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_chord,
  input  logic              key_mode_pulse,
  input  logic              key_ent_pulse,
  input  logic [SW_W-1:0]   sw,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] read_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] display_data,
  output logic [1:0]        mode,
  output logic [2:0]        entry_idx,
  output logic              err
);

  // The final address chunk may be wider than CHUNK_W (up to SW_W bits);
  // the final data chunk may be narrower.
  localparam int N_ACH    = 1 + n_chunks(ADDR_W - SW_W, CHUNK_W);
  localparam int N_DCH    = n_chunks(DATA_W, CHUNK_W);
  localparam int LAST_A_W = ADDR_W - (N_ACH - 1) * CHUNK_W;
  localparam int LAST_D_W = DATA_W - (N_DCH - 1) * CHUNK_W;

  state_t state;
  logic   soft_rst;
  logic   timed_out;

  assign soft_rst = reset || key_chord;

  mem_wait_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .clear  (soft_rst),
    .run    (state == S_WAIT),
    .expired(timed_out)
  );

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state        <= S_IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      write_data   <= '0;
      display_data <= '0;
      mode         <= MODE_IDLE;
      entry_idx    <= '0;
      err          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (key_mode_pulse) begin
            state  <= S_SEL;
            mem_we <= 1'b0;
            mode   <= MODE_READ;
          end
        end

        S_SEL: begin
          if (key_mode_pulse) begin
            mem_we <= ~mem_we;
            mode   <= {~mem_we, mem_we};
          end else if (key_ent_pulse) begin
            state      <= S_ADDR;
            entry_idx  <= '0;
            mem_addr   <= '0;
            write_data <= '0;
          end
        end

        S_ADDR: begin
          if (key_mode_pulse) begin
            state      <= S_SEL;
            mem_addr   <= '0;
            write_data <= '0;
            entry_idx  <= '0;
          end else if (key_ent_pulse) begin
            if (entry_idx == 3'(N_ACH - 1)) begin
              mem_addr[ADDR_W-1 -: LAST_A_W] <= sw[LAST_A_W-1:0];
              entry_idx <= '0;
              if (mem_we) begin
                state <= S_DATA;
              end else begin
                state   <= S_WAIT;
                mem_req <= 1'b1;
              end
            end else begin
              for (int i = 0; i < N_ACH - 1; i++) begin
                if (entry_idx == 3'(i)) begin
                  mem_addr[i*CHUNK_W +: CHUNK_W] <= sw[CHUNK_W-1:0];
                end
              end
              entry_idx <= entry_idx + 3'd1;
            end
          end
        end

        S_DATA: begin
          if (key_mode_pulse) begin
            state      <= S_SEL;
            mem_addr   <= '0;
            write_data <= '0;
            entry_idx  <= '0;
          end else if (key_ent_pulse) begin
            if (entry_idx == 3'(N_DCH - 1)) begin
              write_data[DATA_W-1 -: LAST_D_W] <= sw[LAST_D_W-1:0];
              entry_idx <= '0;
              state     <= S_WAIT;
              mem_req   <= 1'b1;
            end else begin
              for (int i = 0; i < N_DCH - 1; i++) begin
                if (entry_idx == 3'(i)) begin
                  write_data[i*CHUNK_W +: CHUNK_W] <= sw[CHUNK_W-1:0];
                end
              end
              entry_idx <= entry_idx + 3'd1;
            end
          end
        end

        // Completion beats a timeout landing on the same cycle.
        S_WAIT: begin
          if (mem_done) begin
            state   <= S_DONE;
            mem_req <= 1'b0;
            mode    <= MODE_IDLE;
            if (!mem_we) begin
              display_data <= read_data;
            end
          end else if (timed_out) begin
            state   <= S_ERR;
            mem_req <= 1'b0;
            mode    <= MODE_ERR;
            err     <= 1'b1;
          end
        end

        S_DONE: begin
          if (key_mode_pulse) begin
            state      <= S_IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            write_data <= '0;
          end else if (key_ent_pulse) begin
            mem_addr  <= mem_addr + ADDR_W'(1);
            mode      <= {mem_we, ~mem_we};
            entry_idx <= '0;
            if (mem_we) begin
              state      <= S_DATA;
              write_data <= '0;
            end else begin
              state   <= S_WAIT;
              mem_req <= 1'b1;
            end
          end
        end

        S_ERR: begin
          if (key_mode_pulse) begin
            state      <= S_IDLE;
            err        <= 1'b0;
            mode       <= MODE_IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            write_data <= '0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_entry_ctrl.sv
module tb_mem_entry_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_chord = 1'b0;
  logic        key_mode_pulse = 1'b0;
  logic        key_ent_pulse = 1'b0;
  logic [8:0]  sw = '0;
  logic        mem_done = 1'b0;
  logic [15:0] read_data = '0;
  logic        mem_req;
  logic        mem_we;
  logic [24:0] mem_addr;
  logic [15:0] write_data;
  logic [15:0] display_data;
  logic [1:0]  mode;
  logic [2:0]  entry_idx;
  logic        err;

  mem_entry_ctrl #(
    .ADDR_W(25), .DATA_W(16), .SW_W(9), .CHUNK_W(8), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .reset(reset), .key_chord(key_chord),
    .key_mode_pulse(key_mode_pulse), .key_ent_pulse(key_ent_pulse),
    .sw(sw), .mem_done(mem_done), .read_data(read_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .write_data(write_data), .display_data(display_data),
    .mode(mode), .entry_idx(entry_idx), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    bit          frc;
    logic        req;
    logic        we;
    logic [24:0] addr;
    logic [15:0] wd;
    logic [15:0] disp;
    logic [1:0]  md;
    logic [2:0]  idx;
    logic        er;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_on = 0;
  logic [6:0] cur, prev;

  // Expected snapshot after the next active edge (plus dly cycles).
  // frc: compare at that cycle even if no watched output changes.
  task automatic exp_push(input string tag, input bit frc, input logic req,
                          input logic we, input logic [24:0] addr,
                          input logic [15:0] wd, input logic [15:0] disp,
                          input logic [1:0] md, input logic [2:0] idx,
                          input logic er, input int dly);
    exp_t e;
    e.tag = tag; e.frc = frc; e.req = req; e.we = we; e.addr = addr;
    e.wd = wd; e.disp = disp; e.md = md; e.idx = idx; e.er = er;
    e.cyc = cyc + 1 + dly;
    sb.push_back(e);
  endtask

  task automatic drive(input logic m, input logic e, input logic d,
                       input logic [8:0] s = 9'h0, input logic [15:0] rd = 16'h0,
                       input logic ch = 1'b0, input logic rs = 1'b0);
    @(posedge clk);
    #1;
    key_mode_pulse = m;
    key_ent_pulse  = e;
    mem_done       = d;
    sw             = s;
    read_data      = rd;
    key_chord      = ch;
    reset          = rs;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: whenever req/mode/err/idx change (or a forced check is due),
  // pop the oldest expectation and compare the full output set.
  initial begin
    exp_t e;
    bit   fire;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {mem_req, mode, err, entry_idx};
      if (mon_on) begin
        fire = (cur != prev) || (sb.size() > 0 && sb[0].frc && sb[0].cyc == cyc);
        if (fire) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_change: got req=%0b mode=%b err=%0b idx=%0d at cyc=%0d, want no change",
                     mem_req, mode, err, entry_idx, cyc);
          end else begin
            e = sb.pop_front();
            if ({mem_req, mem_we, mem_addr, write_data, display_data, mode, entry_idx, err} !==
                {e.req, e.we, e.addr, e.wd, e.disp, e.md, e.idx, e.er} || cyc != e.cyc) begin
              bad++;
              $display("FAIL %s: got req=%0b we=%0b addr=%h wd=%h disp=%h mode=%b idx=%0d err=%0b cyc=%0d; want req=%0b we=%0b addr=%h wd=%h disp=%h mode=%b idx=%0d err=%0b cyc=%0d",
                       e.tag, mem_req, mem_we, mem_addr, write_data, display_data, mode,
                       entry_idx, err, cyc, e.req, e.we, e.addr, e.wd, e.disp, e.md,
                       e.idx, e.er, e.cyc);
            end
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    mon_on = 1;
    exp_push("reset", 1, 0, 0, 25'h0, 16'h0, 16'h0, 2'b00, 3'd0, 0, 0);
    drive(0, 0, 0);

    // read of 0x1AB1234
    drive(1, 0, 0);
    exp_push("rd_sel", 0, 0, 0, 25'h0, 16'h0, 16'h0, 2'b01, 3'd0, 0, 0);
    drive(0, 1, 0);
    drive(0, 1, 0, 9'h034);
    exp_push("rd_a0", 0, 0, 0, 25'h0000034, 16'h0, 16'h0, 2'b01, 3'd1, 0, 0);
    drive(0, 1, 0, 9'h012);
    exp_push("rd_a1", 0, 0, 0, 25'h0001234, 16'h0, 16'h0, 2'b01, 3'd2, 0, 0);
    drive(0, 1, 0, 9'h1AB);
    exp_push("rd_req", 0, 1, 0, 25'h1AB1234, 16'h0, 16'h0, 2'b01, 3'd0, 0, 0);
    idle(2);
    drive(0, 0, 1, 9'h0, 16'hBEEF);
    exp_push("rd_done", 0, 0, 0, 25'h1AB1234, 16'h0, 16'hBEEF, 2'b00, 3'd0, 0, 0);
    drive(1, 0, 0);
    exp_push("done_idle", 1, 0, 0, 25'h0, 16'h0, 16'hBEEF, 2'b00, 3'd0, 0, 0);

    // write 0xABCD to 0x0010000
    drive(1, 0, 0);
    exp_push("wr_sel", 0, 0, 0, 25'h0, 16'h0, 16'hBEEF, 2'b01, 3'd0, 0, 0);
    drive(1, 0, 0);
    exp_push("wr_tog", 0, 0, 1, 25'h0, 16'h0, 16'hBEEF, 2'b10, 3'd0, 0, 0);
    drive(0, 1, 0);
    drive(0, 1, 0, 9'h000);
    exp_push("wr_a0", 0, 0, 1, 25'h0, 16'h0, 16'hBEEF, 2'b10, 3'd1, 0, 0);
    drive(0, 1, 0, 9'h000);
    exp_push("wr_a1", 0, 0, 1, 25'h0, 16'h0, 16'hBEEF, 2'b10, 3'd2, 0, 0);
    drive(0, 1, 0, 9'h001);
    exp_push("wr_a2", 0, 0, 1, 25'h0010000, 16'h0, 16'hBEEF, 2'b10, 3'd0, 0, 0);
    drive(0, 1, 0, 9'h0CD);
    exp_push("wr_d0", 0, 0, 1, 25'h0010000, 16'h00CD, 16'hBEEF, 2'b10, 3'd1, 0, 0);
    drive(0, 1, 0, 9'h0AB);
    exp_push("wr_req", 0, 1, 1, 25'h0010000, 16'hABCD, 16'hBEEF, 2'b10, 3'd0, 0, 0);
    idle(1);
    drive(0, 0, 1, 9'h0, 16'h1111);
    exp_push("wr_done", 0, 0, 1, 25'h0010000, 16'hABCD, 16'hBEEF, 2'b00, 3'd0, 0, 0);
    drive(0, 1, 0);
    exp_push("wr_inc", 0, 0, 1, 25'h0010001, 16'h0, 16'hBEEF, 2'b10, 3'd0, 0, 0);
    drive(1, 0, 0);
    exp_push("data_abort", 1, 0, 1, 25'h0, 16'h0, 16'hBEEF, 2'b10, 3'd0, 0, 0);
    drive(1, 0, 0);
    exp_push("sel_tog", 0, 0, 0, 25'h0, 16'h0, 16'hBEEF, 2'b01, 3'd0, 0, 0);

    // abort during address entry
    drive(0, 1, 0);
    drive(0, 1, 0, 9'h055);
    exp_push("ab_a0", 0, 0, 0, 25'h0000055, 16'h0, 16'hBEEF, 2'b01, 3'd1, 0, 0);
    drive(1, 0, 0);
    exp_push("addr_abort", 0, 0, 0, 25'h0, 16'h0, 16'hBEEF, 2'b01, 3'd0, 0, 0);

    // both pulses together in SEL: mode toggle wins
    drive(1, 1, 0);
    exp_push("both1", 0, 0, 1, 25'h0, 16'h0, 16'hBEEF, 2'b10, 3'd0, 0, 0);
    drive(1, 1, 0);
    exp_push("both2", 0, 0, 0, 25'h0, 16'h0, 16'hBEEF, 2'b01, 3'd0, 0, 0);

    // read at top address, then auto-increment wraps to 0
    drive(0, 1, 0);
    drive(0, 1, 0, 9'h0FF);
    exp_push("top_a0", 0, 0, 0, 25'h00000FF, 16'h0, 16'hBEEF, 2'b01, 3'd1, 0, 0);
    drive(0, 1, 0, 9'h0FF);
    exp_push("top_a1", 0, 0, 0, 25'h000FFFF, 16'h0, 16'hBEEF, 2'b01, 3'd2, 0, 0);
    drive(0, 1, 0, 9'h1FF);
    exp_push("top_req", 0, 1, 0, 25'h1FFFFFF, 16'h0, 16'hBEEF, 2'b01, 3'd0, 0, 0);
    idle(1);
    drive(0, 0, 1, 9'h0, 16'h1234);
    exp_push("top_done", 0, 0, 0, 25'h1FFFFFF, 16'h0, 16'h1234, 2'b00, 3'd0, 0, 0);
    drive(0, 1, 0);
    exp_push("wrap_req", 0, 1, 0, 25'h0000000, 16'h0, 16'h1234, 2'b01, 3'd0, 0, 0);
    idle(1);
    drive(0, 0, 1, 9'h0, 16'h5678);
    exp_push("wrap_done", 0, 0, 0, 25'h0000000, 16'h0, 16'h5678, 2'b00, 3'd0, 0, 0);

    // timeout: 8 WAIT cycles with keys ignored, then ERR; ERR ignores ent/done
    drive(0, 1, 0);
    exp_push("to_req", 0, 1, 0, 25'h0000001, 16'h0, 16'h5678, 2'b01, 3'd0, 0, 0);
    exp_push("to_err", 0, 0, 0, 25'h0000001, 16'h0, 16'h5678, 2'b11, 3'd0, 1, 8);
    idle(2);
    drive(1, 0, 0);
    drive(0, 1, 0);
    idle(10);
    drive(0, 1, 1, 9'h0, 16'h9999);
    idle(1);
    drive(1, 0, 0);
    exp_push("err_ack", 0, 0, 0, 25'h0, 16'h0, 16'h5678, 2'b00, 3'd0, 0, 0);

    // soft reset mid-WAIT, then a stray completion in IDLE
    drive(1, 0, 0);
    exp_push("ch_sel", 0, 0, 0, 25'h0, 16'h0, 16'h5678, 2'b01, 3'd0, 0, 0);
    drive(0, 1, 0);
    drive(0, 1, 0, 9'h010);
    exp_push("ch_a0", 0, 0, 0, 25'h0000010, 16'h0, 16'h5678, 2'b01, 3'd1, 0, 0);
    drive(0, 1, 0, 9'h020);
    exp_push("ch_a1", 0, 0, 0, 25'h0002010, 16'h0, 16'h5678, 2'b01, 3'd2, 0, 0);
    drive(0, 1, 0, 9'h003);
    exp_push("ch_req", 0, 1, 0, 25'h0032010, 16'h0, 16'h5678, 2'b01, 3'd0, 0, 0);
    idle(2);
    drive(0, 0, 0, 9'h0, 16'h0, 1'b1);
    exp_push("chord", 0, 0, 0, 25'h0, 16'h0, 16'h0, 2'b00, 3'd0, 0, 0);
    drive(0, 0, 1, 9'h0, 16'hDEAD);
    idle(3);
    exp_push("stray_done", 1, 0, 0, 25'h0, 16'h0, 16'h0, 2'b00, 3'd0, 0, 0);
    idle(3);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d pending expectations (next %s), want 0", sb.size(), sb[0].tag);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
